adc_sample_sequencer: RTL and testbench
=======================================

Name: adc_sample_sequencer

Overview:
Sequences the external ADC for the RPM measurement chain. It issues conversion starts at a programmable sample rate and waits for each conversion with a timeout. Each sample is forwarded to the threshold stage as a value plus a toggle-style change flag. A stall watchdog flags the RPM stage when its output stops changing. It sits between the ADC interface and the threshold/rpm datapath.

Parameters:
ADC_WIDTH, 12, width of ADC sample.
SAMPLE_DIV, 1000, clk cycles between conversion starts (>=2).
CONV_TIMEOUT, 256, max clk cycles in CONVERT awaiting adc_done (>=1).
STALL_CYCLES, 1000000, clk cycles without an rpm_change edge before stalled asserts.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  run sequencing; 0 forces IDLE.
clear_err  in  1  one-cycle pulse, clears sticky error flags.
adc_start  out  1  one-cycle conversion-start strobe to ADC.
adc_done  in  1  one-cycle pulse, conversion result valid on adc_data.
adc_data  in  ADC_WIDTH  raw conversion result.
adc_value  out  ADC_WIDTH  last good sample to threshold stage.
adc_value_change  out  1  toggles once per new adc_value.
rpm_change  in  1  change flag from rpm stage; any edge = new rpm.
stalled  out  1  no rpm_change edge for STALL_CYCLES.
timeout_err  out  1  sticky, conversion timed out.
overrun_err  out  1  sticky, sample tick hit while still converting.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; div_cnt, to_cnt, stall_cnt=0; adc_start=0; adc_value=0; adc_value_change=0; stalled=0; timeout_err=0; overrun_err=0; rpm_change edge-detect register loads 0.
- Divider: div_cnt counts 0..SAMPLE_DIV-1 and wraps while enable=1. It is held at 0 while enable=0. tick = (div_cnt==SAMPLE_DIV-1). The divider free-runs regardless of FSM state.
- FSM states: IDLE, WAIT_TICK, START, CONVERT.
  - IDLE: enable=1 -> WAIT_TICK.
  - WAIT_TICK: tick -> START.
  - START: adc_start=1 for exactly this cycle, to_cnt=0 -> CONVERT. adc_start strobes one cycle after the tick cycle.
  - CONVERT: adc_done=1 -> latch adc_data into adc_value, invert adc_value_change, -> WAIT_TICK. Both outputs update on the clock edge that samples adc_done, so they are visible the next cycle.
  - CONVERT timeout: to_cnt==CONV_TIMEOUT-1 with adc_done=0 -> set timeout_err, -> WAIT_TICK, no toggle, adc_value held.
  - CONVERT tick with no adc_done in the same cycle -> set overrun_err. That tick is dropped, not queued.
- adc_done in the same cycle as the timeout limit: done wins; no error is set.
- adc_done outside CONVERT is ignored.
- enable=0 in any state -> IDLE on the next edge. A conversion in flight is abandoned and a later adc_done is ignored. adc_value and the toggle are held. Error flags are held.
- clear_err clears timeout_err and overrun_err. A set and a clear in the same cycle: set wins.
- Stall watchdog, independent of enable:
  - Register rpm_change; edge = rpm_change XOR registered copy.
  - Edge -> stall_cnt=0 and stalled=0 on that edge.
  - Otherwise stall_cnt increments, saturating at STALL_CYCLES. stalled=1 while stall_cnt==STALL_CYCLES.
- Counter widths are $clog2 of each limit, minimum 1 bit. No arithmetic overflow is possible.

Decomposition:
- Shared package/header: ADC_WIDTH default, FSM state encoding (2-bit: IDLE=0, WAIT_TICK=1, START=2, CONVERT=3), default SAMPLE_DIV/CONV_TIMEOUT/STALL_CYCLES.
- One sub-module: stall_watchdog.
  - Parameter: STALL_CYCLES.
  - Ports: clk, rst_n, rpm_change, stalled.
- Divider, FSM and sample register stay in the top module.

Test Plan:
Common settings: SAMPLE_DIV=8, CONV_TIMEOUT=4, STALL_CYCLES=20.
1. Reset release, enable=1 -> first adc_start one cycle after div_cnt==7. ADC model answers adc_done 2 cycles later with 0xABC -> adc_value=0xABC and adc_value_change 0->1. Next adc_start follows exactly 8 cycles after the first.
2. ADC model never answers -> timeout_err=1 after 4 cycles in CONVERT, adc_value unchanged, no toggle. Sequencing resumes at the next tick. clear_err -> timeout_err=0.
3. adc_done on the 4th CONVERT cycle (limit cycle) with 0x123 -> adc_value=0x123, timeout_err stays 0.
4. Temporarily override SAMPLE_DIV=3 with CONV_TIMEOUT=6; ADC answers after 5 cycles -> overrun_err=1 and no extra adc_start. Assert a set and clear_err in the same cycle -> flag remains 1.
5. enable=0 during CONVERT, then a late adc_done with 0xFFF -> adc_value unchanged, no toggle, FSM in IDLE. Re-enable -> adc_start after 8 cycles.
6. Hold rpm_change constant -> stalled=1 after 20 cycles. Toggle rpm_change -> stalled=0 next cycle. Assert rst_n=0 mid-conversion -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/adc_sample_sequencer_pkg.sv
// Shared definitions for the ADC sample sequencer: default sizing, FSM encoding
// and the counter-width helper.
package adc_sample_sequencer_pkg;

  localparam int ADC_WIDTH_DEF    = 12;
  localparam int SAMPLE_DIV_DEF   = 1000;
  localparam int CONV_TIMEOUT_DEF = 256;
  localparam int STALL_CYCLES_DEF = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_START     = 2'd2,
    ST_CONVERT   = 2'd3
  } seq_state_t;

  // Bits needed to hold values 0..limit-1, never less than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/adc_sample_sequencer_stall_watchdog.sv
// Flags the RPM stage as stalled when its toggle-style change flag has not
// moved for STALL_CYCLES clocks.
module adc_sample_sequencer_stall_watchdog
  import adc_sample_sequencer_pkg::*;
#(
  parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rpm_change,
  output logic stalled
);

  // The counter must be able to hold STALL_CYCLES itself, hence the +1.
  localparam int STALL_W = cnt_w(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES);

  logic               rpm_q;
  logic               rpm_edge;
  logic [STALL_W-1:0] stall_cnt;

  assign rpm_edge = rpm_change ^ rpm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpm_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      rpm_q <= rpm_change;
      if (rpm_edge)
        stall_cnt <= '0;
      else if (stall_cnt != STALL_LAST)
        stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign stalled = (stall_cnt == STALL_LAST);

endmodule

// File: rtl/adc_sample_sequencer.sv
// Paces ADC conversions from a free-running divider, guards each conversion
// with a timeout and forwards good samples with a toggle-style change flag.
module adc_sample_sequencer
  import adc_sample_sequencer_pkg::*;
#(
  parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
  parameter int SAMPLE_DIV   = SAMPLE_DIV_DEF,
  parameter int CONV_TIMEOUT = CONV_TIMEOUT_DEF,
  parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear_err,
  output logic                 adc_start,
  input  logic                 adc_done,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic [ADC_WIDTH-1:0] adc_value,
  output logic                 adc_value_change,
  input  logic                 rpm_change,
  output logic                 stalled,
  output logic                 timeout_err,
  output logic                 overrun_err
);

  localparam int DIV_W = cnt_w(SAMPLE_DIV);
  localparam int TO_W  = cnt_w(CONV_TIMEOUT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CONV_TIMEOUT - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             tick;
  logic             sample_ld;
  logic             timeout_set;
  logic             overrun_set;

  assign tick = (div_cnt == DIV_LAST);

  // Sample-rate divider runs whenever enabled, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (!enable || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    adc_start   = 1'b0;
    sample_ld   = 1'b0;
    timeout_set = 1'b0;
    overrun_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable)
          state_nxt = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (tick)
          state_nxt = ST_START;
      end
      ST_START: begin
        adc_start = 1'b1;
        state_nxt = ST_CONVERT;
      end
      ST_CONVERT: begin
        // A done on the timeout limit cycle still counts as a good sample.
        if (adc_done) begin
          sample_ld = 1'b1;
          state_nxt = ST_WAIT_TICK;
        end else begin
          if (to_cnt == TO_LAST) begin
            timeout_set = 1'b1;
            state_nxt   = ST_WAIT_TICK;
          end
          if (tick)
            overrun_set = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Dropping enable abandons whatever is in flight, including a same-cycle done.
    if (!enable) begin
      state_nxt   = ST_IDLE;
      sample_ld   = 1'b0;
      timeout_set = 1'b0;
      overrun_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state == ST_START)
      to_cnt <= '0;
    else if (state == ST_CONVERT && to_cnt != TO_LAST)
      to_cnt <= to_cnt + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_value        <= '0;
      adc_value_change <= 1'b0;
    end else if (sample_ld) begin
      adc_value        <= adc_data;
      adc_value_change <= ~adc_value_change;
    end
  end

  // Sticky flags: a set in the same cycle as clear_err takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (timeout_set)
        timeout_err <= 1'b1;
      else if (clear_err)
        timeout_err <= 1'b0;
      if (overrun_set)
        overrun_err <= 1'b1;
      else if (clear_err)
        overrun_err <= 1'b0;
    end
  end

  adc_sample_sequencer_stall_watchdog #(
    .STALL_CYCLES(STALL_CYCLES)
  ) u_stall_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .rpm_change(rpm_change),
    .stalled   (stalled)
  );

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: a main instance (DIV=8, TO=4,
// STALL=20) and an overrun instance (DIV=3, TO=6), each with a sample scoreboard.
module tb_adc_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // main instance
  logic        enable = 1'b0;
  logic        clear_err = 1'b0;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        rpm_change = 1'b0;
  logic        adc_start;
  logic [11:0] adc_value;
  logic        adc_value_change;
  logic        stalled;
  logic        timeout_err;
  logic        overrun_err;

  // overrun instance
  logic        enable_ov = 1'b0;
  logic        clear_err_ov = 1'b0;
  logic        adc_done_ov = 1'b0;
  logic [11:0] adc_data_ov = '0;
  logic        rpm_change_ov = 1'b0;
  logic        adc_start_ov;
  logic [11:0] adc_value_ov;
  logic        adc_value_change_ov;
  logic        stalled_ov;
  logic        timeout_err_ov;
  logic        overrun_err_ov;

  logic [11:0] exp_q[$];
  logic [11:0] exp_ov_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_sequencer #(
    .ADC_WIDTH(12), .SAMPLE_DIV(8), .CONV_TIMEOUT(4), .STALL_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear_err(clear_err),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .adc_value(adc_value), .adc_value_change(adc_value_change),
    .rpm_change(rpm_change), .stalled(stalled),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  adc_sample_sequencer #(
    .ADC_WIDTH(12), .SAMPLE_DIV(3), .CONV_TIMEOUT(6), .STALL_CYCLES(20)
  ) dut_ov (
    .clk(clk), .rst_n(rst_n), .enable(enable_ov), .clear_err(clear_err_ov),
    .adc_start(adc_start_ov), .adc_done(adc_done_ov), .adc_data(adc_data_ov),
    .adc_value(adc_value_ov), .adc_value_change(adc_value_change_ov),
    .rpm_change(rpm_change_ov), .stalled(stalled_ov),
    .timeout_err(timeout_err_ov), .overrun_err(overrun_err_ov)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Waits (bounded) for a start strobe; returns the cycle stamp it was seen at.
  task automatic wait_start(input bit ov, output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ov ? adc_start_ov : adc_start) && n < 64);
    chk(ov ? "start_seen_ov" : "start_seen", 32'(ov ? adc_start_ov : adc_start), 32'd1);
    t = cyc;
  endtask

  // Main scoreboard: every toggle of the change flag must match a queued sample.
  initial begin : mon_main
    logic prev = 1'b0;
    logic [11:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) prev = adc_value_change;
      else if (adc_value_change != prev) begin
        prev = adc_value_change;
        if (exp_q.size() == 0) chk("unexpected_sample", 32'(adc_value), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("sample_value", 32'(adc_value), 32'(e));
        end
      end
    end
  end

  initial begin : mon_ov
    logic prev = 1'b0;
    logic [11:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) prev = adc_value_change_ov;
      else if (adc_value_change_ov != prev) begin
        prev = adc_value_change_ov;
        if (exp_ov_q.size() == 0) chk("unexpected_sample_ov", 32'(adc_value_ov), 32'hFFFF_FFFF);
        else begin
          e = exp_ov_q.pop_front();
          chk("sample_value_ov", 32'(adc_value_ov), 32'(e));
        end
      end
    end
  end

  initial begin : time_guard
    #100000;
    $display("FAIL time_guard: simulation did not complete, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int t1, t2, t3, t4, t5, t_en, t0, extra;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(adc_start), 32'd0);
    chk("rst_value", 32'(adc_value), 32'd0);
    chk("rst_chg", 32'(adc_value_change), 32'd0);
    chk("rst_errs", {30'd0, timeout_err, overrun_err}, 32'd0);
    chk("rst_stalled", 32'(stalled), 32'd0);

    // 1: first start 8 cycles after release, sample 0xABC
    rst_n = 1'b1;
    enable = 1'b1;
    t0 = cyc;
    wait_start(1'b0, t1);
    chk("first_start_lat", 32'(t1 - t0), 32'd8);
    repeat (2) @(negedge clk);
    adc_done = 1'b1; adc_data = 12'hABC; exp_q.push_back(12'hABC);
    @(negedge clk);
    adc_done = 1'b0;
    chk("chg_after_1", 32'(adc_value_change), 32'd1);

    // 2: no answer -> timeout after 4 CONVERT cycles, then clear
    wait_start(1'b0, t2);
    chk("start_period", 32'(t2 - t1), 32'd8);
    repeat (4) @(negedge clk);
    chk("timeout_not_yet", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("timeout_set", 32'(timeout_err), 32'd1);
    chk("timeout_value_held", 32'(adc_value), 32'hABC);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("timeout_cleared", 32'(timeout_err), 32'd0);

    // 3: done exactly on the limit cycle wins
    wait_start(1'b0, t3);
    chk("resume_period", 32'(t3 - t2), 32'd8);
    repeat (4) @(negedge clk);
    adc_done = 1'b1; adc_data = 12'h123; exp_q.push_back(12'h123);
    @(negedge clk);
    adc_done = 1'b0;
    chk("limit_no_timeout", 32'(timeout_err), 32'd0);
    chk("limit_value", 32'(adc_value), 32'h123);

    // 5: disable mid-conversion, late done ignored, re-enable
    wait_start(1'b0, t4);
    chk("period_after_limit", 32'(t4 - t3), 32'd8);
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    adc_done = 1'b1; adc_data = 12'hFFF;
    @(negedge clk);
    adc_done = 1'b0;
    enable = 1'b1;
    t_en = cyc;
    chk("late_done_value", 32'(adc_value), 32'h123);
    chk("late_done_chg", 32'(adc_value_change), 32'd0);
    wait_start(1'b0, t5);
    chk("reenable_lat", 32'(t5 - t_en), 32'd8);

    // 6: stall watchdog, then reset mid-conversion
    chk("stalled_before", 32'(stalled), 32'd1);
    rpm_change = 1'b1;
    @(negedge clk);
    chk("stalled_clear", 32'(stalled), 32'd0);
    repeat (19) @(negedge clk);
    chk("stalled_at_19", 32'(stalled), 32'd0);
    @(negedge clk);
    chk("stalled_at_20", 32'(stalled), 32'd1);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    wait_start(1'b0, t1);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_start", 32'(adc_start), 32'd0);
    chk("arst_value", 32'(adc_value), 32'd0);
    chk("arst_chg", 32'(adc_value_change), 32'd0);
    chk("arst_stalled", 32'(stalled), 32'd0);
    chk("arst_errs", {30'd0, timeout_err, overrun_err}, 32'd0);
    repeat (2) @(negedge clk);

    // 4: overrun instance, DIV=3, TO=6, answer after 5 CONVERT cycles
    rst_n = 1'b1;
    enable_ov = 1'b1;
    t0 = cyc;
    wait_start(1'b1, t1);
    chk("ov_first_lat", 32'(t1 - t0), 32'd3);
    extra = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (adc_start_ov) extra++;
      if (i == 2) chk("ov_before_tick", 32'(overrun_err_ov), 32'd0);
      if (i == 3) chk("ov_set", 32'(overrun_err_ov), 32'd1);
      if (i == 5) begin
        adc_done_ov = 1'b1; adc_data_ov = 12'h3C3; exp_ov_q.push_back(12'h3C3);
      end
    end
    @(negedge clk);
    adc_done_ov = 1'b0;
    chk("ov_no_extra_start", 32'(extra), 32'd0);
    clear_err_ov = 1'b1;
    @(negedge clk);
    clear_err_ov = 1'b0;
    chk("ov_cleared", 32'(overrun_err_ov), 32'd0);
    wait_start(1'b1, t2);
    chk("ov_period", 32'(t2 - t1), 32'd9);
    @(negedge clk);
    @(negedge clk);
    clear_err_ov = 1'b1;
    @(negedge clk);
    clear_err_ov = 1'b0;
    chk("ov_set_beats_clear", 32'(overrun_err_ov), 32'd1);
    repeat (2) @(negedge clk);
    adc_done_ov = 1'b1; adc_data_ov = 12'h5A5; exp_ov_q.push_back(12'h5A5);
    @(negedge clk);
    adc_done_ov = 1'b0;
    repeat (2) @(negedge clk);
    chk("ov_no_timeout", 32'(timeout_err_ov), 32'd0);
    chk("ov_stalled", 32'(stalled_ov), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("queue_ov_drained", 32'(exp_ov_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
